apb_soc_timer: RTL
==================

Name: apb_soc_timer

Overview:
- APB slave peripheral on the SoC peripheral APB bus, decoded as a third slave at 0x1A10_5000–0x1A10_5FFF, next to the stdout and SoC control register slaves.
- 64-bit free-running timer with an 8-bit prescaler, one 64-bit compare, an optional periodic auto-advance of the compare, and a level interrupt toward the cluster event units.
- Gives host and cores a shared time base.

Parameters:
- ADDR_WIDTH, 32, APB address width. Only paddr[11:0] is decoded.
- DATA_WIDTH, 32, APB data width. Fixed at 32; elaboration error otherwise.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- paddr_i  in  ADDR_WIDTH  APB address
- pwdata_i  in  32  APB write data
- pwrite_i  in  1  APB write
- psel_i  in  1  APB select
- penable_i  in  1  APB enable
- prdata_o  out  32  APB read data
- pready_o  out  1  APB ready
- pslverr_o  out  1  APB error
- irq_o  out  1  level interrupt, high while pending & irq_en

Behaviour:
- APB protocol
  - Zero-wait: pready_o=1 whenever psel_i & penable_i, else 0.
  - An access completes on the edge with psel & penable.
  - Writes take effect at that edge.
  - prdata_o is combinational from flops during the access phase, else 0.
- Register map (offsets; word aligned)
  - 0x00 CTRL: [0] en, [1] irq_en, [2] periodic, [15:8] prescale; other bits RAZ/WI.
  - 0x04 STATUS: [0] pending; write 1 to clear.
  - 0x08 COUNT_LO: reading latches count[63:32] into hi_shadow at the completing edge.
  - 0x0C COUNT_HI: reads return hi_shadow; writes go to count[63:32] directly.
  - 0x10 CMP_LO, 0x14 CMP_HI.
  - 0x18 PERIOD: 32-bit, zero-extended when added.
  - Unmapped offsets or paddr[1:0]!=0: pslverr_o=1, prdata_o=0, no state change.
- Reset values (rst_i at clk_i edge, any state)
  - All registers 0, including pre_cnt and hi_shadow; cmp is 0.
  - prdata_o=0, pready_o=0, pslverr_o=0, irq_o=0.
- Prescaler
  - When en=1: pre_cnt increments each cycle. tick when pre_cnt==prescale, then pre_cnt<=0.
  - prescale=0 gives a tick every cycle.
  - When en=0: pre_cnt and count hold.
  - Any CTRL write clears pre_cnt.
- Counter
  - count <= count+1 on tick, modulo 2^64 (0xFFFF_FFFF_FFFF_FFFF -> 0).
- Compare
  - Match when a tick makes count take the value cmp (equality on the new value).
  - On match: pending<=1 at the same edge.
  - If periodic=1, cmp <= cmp + PERIOD (mod 2^64) at the same edge.
  - No match fires while en=0.
- Interrupt
  - irq_o = pending & irq_en.
  - Visible the cycle after the matching edge; no combinational path from APB.
- Simultaneous events
  - APB write to COUNT_LO/HI in a tick cycle: the write wins, no increment, no match, pre_cnt cleared.
  - APB write to CMP_LO/HI in a match cycle: match uses the old cmp and pending sets; the written value wins over the periodic reload.
  - STATUS W1C in a match cycle: set wins, pending stays 1.
  - COUNT_LO read in a tick cycle: returns the pre-increment low word; hi_shadow captures the pre-increment high word.
- Writing cmp to a value already passed: no event until count wraps to it.

Test Plan:
- Reset: assert rst_i for 2 cycles mid-count with pending=1 → irq_o=0; all registers read 0; pready_o low outside the access phase.
- Prescale: CTRL=0x0000_0301 (en, prescale=3), run 40 cycles → COUNT_LO reads 10 (±1 per the read edge); pre_cnt period exactly 4 cycles.
- Compare: CMP=0x20, CTRL=0x3 (en, irq_en, prescale 0) → irq_o rises exactly 0x20 ticks after enable; W1C STATUS=1 → irq_o low next cycle.
- Periodic: CMP=0x10, PERIOD=0x8, CTRL=0x7 → pending sets at counts 0x10, 0x18, 0x20 (clear between); CMP reads 0x28 afterwards.
- 64-bit wrap/atomic read: write COUNT_HI=0, COUNT_LO=0xFFFF_FFFE, en → reading LO=0xFFFF_FFFF then HI returns 0 (the shadow), not 1.
- Error/collision: read 0x1C → pslverr_o=1, prdata_o=0; STATUS W1C coincident with a match → pending stays 1.

Source files
------------

// File: rtl/apb_soc_timer.sv
// APB timer slave: 64-bit free-running counter with an 8-bit prescaler,
// one 64-bit compare with optional periodic advance, and a level interrupt.
module apb_soc_timer #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] paddr_i,
  input  logic [DATA_WIDTH-1:0] pwdata_i,
  input  logic                  pwrite_i,
  input  logic                  psel_i,
  input  logic                  penable_i,
  output logic [DATA_WIDTH-1:0] prdata_o,
  output logic                  pready_o,
  output logic                  pslverr_o,
  output logic                  irq_o
);

  if (DATA_WIDTH != 32) begin : g_bad_data_width
    $error("apb_soc_timer: DATA_WIDTH must be 32");
  end
  if (ADDR_WIDTH < 13) begin : g_bad_addr_width
    $error("apb_soc_timer: ADDR_WIDTH must be at least 13");
  end

  localparam logic [2:0] RegCtrl    = 3'd0;
  localparam logic [2:0] RegStatus  = 3'd1;
  localparam logic [2:0] RegCountLo = 3'd2;
  localparam logic [2:0] RegCountHi = 3'd3;
  localparam logic [2:0] RegCmpLo   = 3'd4;
  localparam logic [2:0] RegCmpHi   = 3'd5;
  localparam logic [2:0] RegPeriod  = 3'd6;

  logic        r_en;
  logic        r_irq_en;
  logic        r_periodic;
  logic [7:0]  r_prescale;
  logic [7:0]  r_pre_cnt;
  logic        r_pending;
  logic [63:0] r_count;
  logic [63:0] r_cmp;
  logic [31:0] r_period;
  logic [31:0] r_hi_shadow;

  logic        w_access;
  logic        w_mapped;
  logic [2:0]  w_idx;
  logic        w_wr;
  logic        w_rd;
  logic        w_wr_ctrl;
  logic        w_wr_status;
  logic        w_wr_count_lo;
  logic        w_wr_count_hi;
  logic        w_wr_cmp_lo;
  logic        w_wr_cmp_hi;
  logic        w_wr_period;
  logic        w_rd_count_lo;
  logic        w_count_wr;
  logic        w_tick;
  logic        w_match;
  logic [63:0] w_count_inc;
  logic [63:0] w_cmp_reload;
  logic [31:0] w_rdata;
  logic        w_unused_addr;

  // Only the low 12 address bits select a register within the 4 KiB window.
  assign w_unused_addr = ^paddr_i[ADDR_WIDTH-1:12];

  assign w_access = psel_i & penable_i;
  assign w_idx    = paddr_i[4:2];
  assign w_mapped = (paddr_i[1:0] == 2'b00) && (paddr_i[11:5] == 7'd0) && (w_idx != 3'd7);
  assign w_wr     = w_access & pwrite_i & w_mapped;
  assign w_rd     = w_access & ~pwrite_i & w_mapped;

  assign w_wr_ctrl     = w_wr && (w_idx == RegCtrl);
  assign w_wr_status   = w_wr && (w_idx == RegStatus);
  assign w_wr_count_lo = w_wr && (w_idx == RegCountLo);
  assign w_wr_count_hi = w_wr && (w_idx == RegCountHi);
  assign w_wr_cmp_lo   = w_wr && (w_idx == RegCmpLo);
  assign w_wr_cmp_hi   = w_wr && (w_idx == RegCmpHi);
  assign w_wr_period   = w_wr && (w_idx == RegPeriod);
  assign w_rd_count_lo = w_rd && (w_idx == RegCountLo);
  assign w_count_wr    = w_wr_count_lo | w_wr_count_hi;

  assign w_tick       = r_en && (r_pre_cnt == r_prescale);
  assign w_count_inc  = r_count + 64'd1;
  // A software count write suppresses both the increment and the compare.
  assign w_match      = w_tick && !w_count_wr && (w_count_inc == r_cmp);
  assign w_cmp_reload = r_cmp + {32'd0, r_period};

  always_comb begin
    w_rdata = 32'd0;
    case (w_idx)
      RegCtrl:    w_rdata = {16'd0, r_prescale, 5'd0, r_periodic, r_irq_en, r_en};
      RegStatus:  w_rdata = {31'd0, r_pending};
      RegCountLo: w_rdata = r_count[31:0];
      RegCountHi: w_rdata = r_hi_shadow;
      RegCmpLo:   w_rdata = r_cmp[31:0];
      RegCmpHi:   w_rdata = r_cmp[63:32];
      RegPeriod:  w_rdata = r_period;
      default:    w_rdata = 32'd0;
    endcase
  end

  assign prdata_o  = (w_access && w_mapped) ? w_rdata : 32'd0;
  assign pready_o  = w_access;
  assign pslverr_o = w_access & ~w_mapped;
  assign irq_o     = r_pending & r_irq_en;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_en        <= 1'b0;
      r_irq_en    <= 1'b0;
      r_periodic  <= 1'b0;
      r_prescale  <= 8'd0;
      r_pre_cnt   <= 8'd0;
      r_pending   <= 1'b0;
      r_count     <= 64'd0;
      r_cmp       <= 64'd0;
      r_period    <= 32'd0;
      r_hi_shadow <= 32'd0;
    end else begin
      if (w_wr_ctrl) begin
        r_en       <= pwdata_i[0];
        r_irq_en   <= pwdata_i[1];
        r_periodic <= pwdata_i[2];
        r_prescale <= pwdata_i[15:8];
        r_pre_cnt  <= 8'd0;
      end else if (r_en) begin
        r_pre_cnt <= w_tick ? 8'd0 : r_pre_cnt + 8'd1;
      end

      if (w_wr_count_lo) begin
        r_count[31:0] <= pwdata_i;
      end else if (w_wr_count_hi) begin
        r_count[63:32] <= pwdata_i;
      end else if (w_tick) begin
        r_count <= w_count_inc;
      end

      // A match sets pending even when software clears it in the same cycle.
      if (w_match) begin
        r_pending <= 1'b1;
      end else if (w_wr_status && pwdata_i[0]) begin
        r_pending <= 1'b0;
      end

      if (w_wr_cmp_lo) begin
        r_cmp[31:0] <= pwdata_i;
      end else if (w_wr_cmp_hi) begin
        r_cmp[63:32] <= pwdata_i;
      end else if (w_match && r_periodic) begin
        r_cmp <= w_cmp_reload;
      end

      if (w_wr_period) begin
        r_period <= pwdata_i;
      end

      // Snapshot the high word so a LO-then-HI read pair is atomic.
      if (w_rd_count_lo) begin
        r_hi_shadow <= r_count[63:32];
      end
    end
  end

endmodule
